// File: rtl/sysbus_pkg.sv
// Shared types and constants for the system_bus command decoder.
// Holds the opcode encodings, the decoder FSM state type and the queued command record.
package sysbus_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_WRITE = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA_LO,
        ST_WDATA_HI
    } dec_state_e;

    typedef struct packed {
        logic        is_write;
        logic [27:0] addr;
        logic [63:0] wdata;
    } sysbus_cmd_t;

endpackage

// File: rtl/sysbus_cmd_fifo.sv
// Synchronous command FIFO with no fall-through and an exact occupancy count.
// When it is full, a push is accepted only if a pop happens in the same cycle.
// A push that is refused is reported on drop_o.
module sysbus_cmd_fifo
    import sysbus_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  sysbus_cmd_t   push_data_i,
    input  logic          pop_i,
    output sysbus_cmd_t   head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output logic          push_ok_o,
    output logic          drop_o
);

    sysbus_cmd_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == LW'(DEPTH));
    assign level_o   = count_q;
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];
    assign push_ok_o = do_push;
    assign drop_o    = push_i && !do_push;

    // Work out which transfers happen and the next pointer and count values.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage. No reset is needed because the head output is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sysbus_cmd_decoder.sv
// Parses the system_bus beat stream into read and write commands for the DDR5 controller.
// A header is {opcode[3:0], addr[27:0]}. A write header is followed by a low data beat and then a high data beat.
// Each completed command spends one cycle in a staging register before it enters the FIFO.
// Optional macro SYSBUS_CMD_STATS_EN adds saturating counters of accepted writes and reads.
module sysbus_cmd_decoder
    import sysbus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned DATA_W     = 64,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       system_bus,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_is_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic [LVL_W-1:0]  fifo_level,
`ifdef SYSBUS_CMD_STATS_EN
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
`endif
    output logic              overflow_err,
    output logic              protocol_err
);

    dec_state_e  state_q, state_d;
    logic [27:0] addr_q, addr_d;
    logic [31:0] wlo_q, wlo_d;
    logic        stage_vld_q, stage_vld_d;
    sysbus_cmd_t stage_cmd_q, stage_cmd_d;
    logic        ovf_q, perr_q, perr_set;
    logic [3:0]  opcode;

    sysbus_cmd_t head;
    logic        fifo_empty, fifo_full, push_ok, drop;

    assign opcode = system_bus[31:28];

    // Decoder FSM: next state, latches and staged command.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wlo_d       = wlo_q;
        stage_vld_d = 1'b0;
        stage_cmd_d = '0;
        perr_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (opcode)
                    OP_NOP: ;
                    OP_WRITE: begin
                        addr_d  = system_bus[27:0];
                        state_d = ST_WDATA_LO;
                    end
                    OP_READ: begin
                        stage_vld_d          = 1'b1;
                        stage_cmd_d.is_write = 1'b0;
                        stage_cmd_d.addr     = system_bus[27:0];
                        stage_cmd_d.wdata    = '0;
                    end
                    default: perr_set = 1'b1;
                endcase
            end
            ST_WDATA_LO: begin
                wlo_d   = system_bus;
                state_d = ST_WDATA_HI;
            end
            ST_WDATA_HI: begin
                stage_vld_d          = 1'b1;
                stage_cmd_d.is_write = 1'b1;
                stage_cmd_d.addr     = addr_q;
                stage_cmd_d.wdata    = {system_bus, wlo_q};
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latches, staging register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wlo_q       <= '0;
            stage_vld_q <= 1'b0;
            stage_cmd_q <= '0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wlo_q       <= wlo_d;
            stage_vld_q <= stage_vld_d;
            stage_cmd_q <= stage_cmd_d;
            if (drop)     ovf_q  <= 1'b1;
            if (perr_set) perr_q <= 1'b1;
        end
    end

    sysbus_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (stage_vld_q),
        .push_data_i (stage_cmd_q),
        .pop_i       (cmd_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .push_ok_o   (push_ok),
        .drop_o      (drop)
    );

    assign cmd_valid    = !fifo_empty;
    assign cmd_is_write = head.is_write;
    assign cmd_addr     = ADDR_W'(head.addr);
    assign cmd_wdata    = DATA_W'(head.wdata);
    assign overflow_err = ovf_q;
    assign protocol_err = perr_q;

`ifdef SYSBUS_CMD_STATS_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    // Saturating counts of commands that the FIFO accepted. Dropped commands are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (push_ok) begin
            if (stage_cmd_q.is_write) begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sysbus_cmd_decoder.sv
// Scoreboard bench for sysbus_cmd_decoder.
// The driver pushes hand-computed expected commands into a queue.
// The monitor compares every command popped at the DUT output against that queue.
module tb_sysbus_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] system_bus;
    logic        cmd_valid, cmd_ready, cmd_is_write;
    logic [27:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [2:0]  fifo_level;
    logic        overflow_err, protocol_err;
`ifdef SYSBUS_CMD_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    typedef struct packed {
        logic        w;
        logic [27:0] a;
        logic [63:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    sysbus_cmd_decoder #(
        .FIFO_DEPTH (4),
        .ADDR_W     (28),
        .DATA_W     (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .system_bus   (system_bus),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is_write (cmd_is_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .fifo_level   (fifo_level),
`ifdef SYSBUS_CMD_STATS_EN
        .wr_count     (wr_count),
        .rd_count     (rd_count),
`endif
        .overflow_err (overflow_err),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Drive one beat; the DUT samples it at the next rising edge.
    task automatic step(input logic [31:0] b);
        system_bus = b;
        @(posedge clk);
        #1;
    endtask

    // Monitor: on every accepted pop, compare the head against the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", {35'd0, cmd_is_write, cmd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("head_is_write", {63'd0, cmd_is_write}, {63'd0, e.w});
                chk("head_addr", {36'd0, cmd_addr}, {36'd0, e.a});
                chk("head_wdata", cmd_wdata, e.d);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        system_bus = '0;
        cmd_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", {63'd0, cmd_valid}, 64'd0);
        chk("rst_level", {61'd0, fifo_level}, 64'd0);
        chk("rst_errs", {62'd0, overflow_err, protocol_err}, 64'd0);
        chk("rst_head", {cmd_addr[27:0], cmd_wdata[35:0]}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write: header at edge N, valid after N+3, high for exactly one cycle.
        exp_q.push_back('{1'b1, 28'h000_1000, 64'hABCD_1234_5678_90EF});
        step(32'h3000_1000);
        step(32'h5678_90EF);
        step(32'hABCD_1234);
        system_bus = '0;
        @(negedge clk);
        chk("wr_lat_n2", {63'd0, cmd_valid}, 64'd0);
        step('0);
        @(negedge clk);
        chk("wr_lat_n3", {63'd0, cmd_valid}, 64'd1);
        step('0);
        @(negedge clk);
        chk("wr_one_cycle", {63'd0, cmd_valid}, 64'd0);

        // Read: valid after N+1.
        exp_q.push_back('{1'b0, 28'h000_1000, 64'd0});
        step(32'h2000_1000);
        system_bus = '0;
        @(negedge clk);
        chk("rd_lat_n0", {63'd0, cmd_valid}, 64'd0);
        step('0);
        @(negedge clk);
        chk("rd_lat_n1", {63'd0, cmd_valid}, 64'd1);
        step('0);

        // A data beat that looks like a READ header is treated as data.
        exp_q.push_back('{1'b1, 28'h000_0ABC, 64'h0000_0001_2000_0000});
        step(32'h3000_0ABC);
        step(32'h2000_0000);
        step(32'h0000_0001);
        repeat (5) step('0);
        @(negedge clk);
        chk("opc_as_data_level", {61'd0, fifo_level}, 64'd0);

        // Overflow: five reads are issued while the FIFO is stalled. The first four are kept in order.
        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back('{1'b0, 28'(i), 64'd0});
            step(32'h2000_0000 | 32'(i));
        end
        step('0);
        step('0);
        @(negedge clk);
        chk("full_level", {61'd0, fifo_level}, 64'd4);
        chk("overflow_err", {63'd0, overflow_err}, 64'd1);
        chk("stall_head_addr", {36'd0, cmd_addr}, 64'd1);
        step('0);
        @(negedge clk);
        chk("stall_head_stable", {36'd0, cmd_addr}, 64'd1);
        step('0);
        cmd_ready = 1'b1;
        repeat (6) step('0);
        @(negedge clk);
        chk("drain_level", {61'd0, fifo_level}, 64'd0);

        // Unknown opcode: the error flag is set and nothing is pushed.
        step(32'h7000_0000);
        step('0);
        @(negedge clk);
        chk("protocol_err", {63'd0, protocol_err}, 64'd1);
        chk("perr_no_push", {61'd0, fifo_level}, 64'd0);
        exp_q.push_back('{1'b0, 28'h000_0042, 64'd0});
        step(32'h2000_0042);
        repeat (4) step('0);

        // Reset after the low data beat discards the partial write.
        step(32'h3000_0500);
        step(32'h1111_1111);
        reset = 1'b1;
        step(32'h2222_2222);
        step('0);
        reset = 1'b0;
        repeat (3) step('0);
        @(negedge clk);
        chk("midrst_valid", {63'd0, cmd_valid}, 64'd0);
        chk("midrst_errs", {61'd0, fifo_level}, {61'd0, 3'd0});
        chk("midrst_flags", {62'd0, overflow_err, protocol_err}, 64'd0);
        exp_q.push_back('{1'b1, 28'h000_0600, 64'hCAFE_F00D_DEAD_BEEF});
        step(32'h3000_0600);
        step(32'hDEAD_BEEF);
        step(32'hCAFE_F00D);
        repeat (6) step('0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sysbus_cmd_decoder.md
Name: sysbus_cmd_decoder

Overview:
Front-end stage directly upstream of the DDR5 memory controller core. Parses the 32-bit system_bus beat stream into complete read/write commands. A write is an opcode/address header beat followed by two data beats. Completed commands are queued in a small FIFO and presented to the controller's scheduler over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of queued commands; power of two, 2..16.
- ADDR_W, 28, command address width, taken from system_bus[27:0].
- DATA_W, 64, write payload width, assembled from two 32-bit beats.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- system_bus  in  32  one beat per clock. Header format is {opcode[3:0], addr[27:0]}.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  downstream accepts the head this cycle.
- cmd_is_write  out  1  head is a write (1) or a read (0).
- cmd_addr  out  ADDR_W  head address.
- cmd_wdata  out  DATA_W  head write data; zero for reads.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued entries.
- overflow_err  out  1  sticky: a completed command was dropped because the FIFO was full.
- protocol_err  out  1  sticky: an unknown nonzero opcode was seen in a header slot.

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, data and address latches cleared. Reset has priority over everything; a reset mid-write discards the partial packet.
- Opcodes (system_bus[31:28]) are sampled only in IDLE:
  - 4'h0 = no-op.
  - 4'h3 = WRITE.
  - 4'h2 = READ.
  - Any other value sets protocol_err, is ignored, and the FSM stays in IDLE.
- FSM states and transitions:
  - IDLE: on WRITE, latch addr and go to WDATA_LO. On READ, push {rd, addr, 64'h0} and stay in IDLE.
  - WDATA_LO: latch system_bus into wdata[31:0], whatever its value (all-zero and opcode-like values are data here). Go to WDATA_HI.
  - WDATA_HI: latch system_bus into wdata[63:32], push {wr, addr, wdata}, go to IDLE.
- Latency, with the header sampled at edge N and the FIFO empty:
  - Read: cmd_valid is high after edge N+1.
  - Write: cmd_valid is high after edge N+3.
  - Header-to-valid timing is fixed and does not depend on cmd_ready.
- Handshake:
  - A pop occurs on cmd_valid && cmd_ready.
  - Head outputs are stable while cmd_valid=1 and cmd_ready=0.
  - cmd_ready while empty has no effect.
- Full boundary:
  - A push when full and no pop in the same cycle drops the command and sets overflow_err.
  - A push and a pop in the same cycle when full both succeed; level stays at FIFO_DEPTH.
- Empty boundary: a push and a pop in the same cycle when empty leaves the FIFO empty only after the pushed entry is first presented; there is no fall-through, so the push is visible on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is an exact count, 0..FIFO_DEPTH.
- Sticky error flags clear only on reset.

Optional Feature:
SYSBUS_CMD_STATS_EN
- When defined: adds outputs wr_count[15:0] and rd_count[15:0]. Each counts commands accepted into the FIFO, saturates at 16'hFFFF, and resets to 0. Dropped commands are not counted.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package sysbus_pkg contains:
  - opcode localparams OP_NOP=4'h0, OP_READ=4'h2, OP_WRITE=4'h3;
  - the decoder FSM state enum;
  - packed struct sysbus_cmd_t {is_write, addr[27:0], wdata[63:0]}.
- Sub-module sysbus_cmd_fifo: a synchronous FIFO of sysbus_cmd_t with push/pop/full/empty/level. The decoder FSM stays in the top module.

Test Plan:
- Write header 32'h3000_1000, beats 32'h5678_90EF then 32'hABCD_1234, with cmd_ready=1 → cmd_valid at N+3 with is_write=1, addr=28'h000_1000, wdata=64'hABCD_1234_5678_90EF for exactly one cycle.
- Read header 32'h2000_1000 → cmd_valid at N+1 with is_write=0, addr=28'h000_1000, wdata=0.
- Write data beat equal to 32'h2000_0000 → treated as data; no read is issued; wdata[31:0]=32'h2000_0000.
- cmd_ready=0, then 5 reads with FIFO_DEPTH=4 → fifo_level=4, overflow_err=1, first four addresses retained in order. Then cmd_ready=1 → four pops in order, level returns to 0.
- Header 32'h7000_0000 → protocol_err=1, no push. A subsequent valid read is still accepted.
- Reset asserted after the WDATA_LO beat → all outputs 0, no command emitted. The next write completes normally.
